// File: rtl/pll_ctrl_pkg.sv
// PLL supervisor shared types: FSM state encoding and default parameters.
// Imported by pll_reset_ctrl. Optional build macro: PLL_LOSS_CNT_EN (see top).
package pll_ctrl_pkg;

    typedef enum logic [1:0] {
        RST    = 2'd0,
        WAIT   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    localparam int RESET_CYCLES_DEF = 16;
    localparam int LOCK_TIMEOUT_DEF = 27000;
    localparam int LOCK_FILTER_DEF  = 8;
    localparam int MAX_RETRIES_DEF  = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser for asynchronous inputs.
// Ports: clk_i, rst_i (sync, active-high), d_i async in, q_o synchronised out.
module sync_2ff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses PLL RESET, qualifies LOCK, retries, faults.
// Ports: clk_i, rst_i (sync, active-high), lock_i (async), relock_i,
//   pll_rst_o, locked_o, fault_o (sticky), retries_o, and loss_cnt_o
//   when built with PLL_LOSS_CNT_EN defined (lock-loss event counter).
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int LOCK_FILTER  = LOCK_FILTER_DEF,
    parameter int MAX_RETRIES  = MAX_RETRIES_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             lock_i,
    input  logic                             relock_i,
    output logic                             pll_rst_o,
    output logic                             locked_o,
    output logic                             fault_o,
`ifdef PLL_LOSS_CNT_EN
    output logic [15:0]                      loss_cnt_o,
`endif
    output logic [$clog2(MAX_RETRIES+1)-1:0] retries_o
);

    localparam int CW = max2(1, $clog2(max2(RESET_CYCLES, LOCK_TIMEOUT)));
    localparam int FW = max2(1, $clog2(LOCK_FILTER + 1));
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RC_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [FW-1:0] LF_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRIES);

    state_e        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [FW-1:0] filt_q, filt_n;
    logic [RW-1:0] retr_q, retr_n;
    logic          lock_s;

    sync_2ff #(.W(1), .RST_VAL(1'b0)) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (lock_i),
        .q_o   (lock_s)
    );

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        filt_n  = filt_q;
        retr_n  = retr_q;
        if (relock_i) begin
            state_n = RST;
            cnt_n   = '0;
            filt_n  = '0;
            retr_n  = '0;
        end else begin
            unique case (state_q)
                RST: begin
                    if (cnt_q == RC_LAST) begin
                        state_n = WAIT;
                        cnt_n   = '0;
                        filt_n  = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    cnt_n  = cnt_q + 1'b1;
                    filt_n = lock_s ? filt_q + 1'b1 : '0;
                    // Qualification is checked first so it wins over timeout.
                    if (lock_s && filt_q == LF_LAST) begin
                        state_n = LOCKED;
                        cnt_n   = '0;
                        filt_n  = '0;
                        retr_n  = '0;
                    end else if (cnt_q == LT_LAST) begin
                        cnt_n  = '0;
                        filt_n = '0;
                        if (retr_q == R_MAX) begin
                            state_n = FAULT;
                        end else begin
                            state_n = RST;
                            retr_n  = retr_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (!lock_s) begin
                        state_n = RST;
                        cnt_n   = '0;
                        filt_n  = '0;
                    end
                end
                FAULT: begin
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with
    // the transition edge rather than trailing it by a cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RST;
            cnt_q     <= '0;
            filt_q    <= '0;
            retr_q    <= '0;
            pll_rst_o <= 1'b1;
            locked_o  <= 1'b0;
            fault_o   <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            filt_q    <= filt_n;
            retr_q    <= retr_n;
            pll_rst_o <= (state_n == RST) || (state_n == FAULT);
            locked_o  <= (state_n == LOCKED);
            fault_o   <= (state_n == FAULT);
        end
    end

    assign retries_o = retr_q;

`ifdef PLL_LOSS_CNT_EN
    logic loss_ev;

    assign loss_ev = !relock_i && (state_q == LOCKED) && !lock_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loss_cnt_o <= '0;
        end else if (loss_ev && loss_cnt_o != 16'hFFFF) begin
            loss_cnt_o <= loss_cnt_o + 16'd1;
        end
    end
`endif

endmodule
